// File: rtl/my_cpu_pkg.sv
// Shared Hack ISA definitions: word/address widths, instruction field positions
// and the decoded control-word types used by the CPU stage and its ALU.
package my_cpu_pkg;

  localparam int WORD      = 16;
  localparam int ADDR      = 15;

  localparam int BIT_CINST = 15;
  localparam int BIT_A     = 12;
  localparam int COMP_HI   = 11;
  localparam int COMP_LO   = 6;
  localparam int DEST_A    = 5;
  localparam int DEST_D    = 4;
  localparam int DEST_M    = 3;
  localparam int JMP_LT    = 2;
  localparam int JMP_EQ    = 1;
  localparam int JMP_GT    = 0;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  typedef struct packed {
    logic      cinst;
    logic      a;
    alu_ctrl_t comp;
    logic      dst_a;
    logic      dst_d;
    logic      dst_m;
    logic      j_lt;
    logic      j_eq;
    logic      j_gt;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [WORD-1:0] inst);
    ctrl_t c;
    c.cinst = inst[BIT_CINST];
    c.a     = inst[BIT_A];
    c.comp  = alu_ctrl_t'(inst[COMP_HI:COMP_LO]);
    c.dst_a = inst[DEST_A];
    c.dst_d = inst[DEST_D];
    c.dst_m = inst[DEST_M];
    c.j_lt  = inst[JMP_LT];
    c.j_eq  = inst[JMP_EQ];
    c.j_gt  = inst[JMP_GT];
    return c;
  endfunction

endpackage

// File: rtl/my_cpu_alu.sv
// Hack 16-bit ALU: optional zero/negate of each operand, add or AND,
// optional negate of the result.
module hack_alu
  import my_cpu_pkg::*;
(
  input  logic [WORD-1:0] x,
  input  logic [WORD-1:0] y,
  input  alu_ctrl_t       ctrl,
  output logic [WORD-1:0] out,
  output logic            zr,
  output logic            ng
);

  logic [WORD-1:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z = ctrl.zx ? '0 : x;
    x_n = ctrl.nx ? ~x_z : x_z;
    y_z = ctrl.zy ? '0 : y;
    y_n = ctrl.ny ? ~y_z : y_z;
    res = ctrl.f ? (x_n + y_n) : (x_n & y_n);
    out = ctrl.no ? ~res : res;
  end

  assign zr = (out == '0);
  assign ng = out[WORD-1];

endmodule

// File: rtl/my_cpu_pc.sv
// Program counter: 15-bit register with async clear, hold, load and
// wrapping increment (priority reset > hold > load > increment).
module my_pc
  import my_cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            load,
  input  logic [ADDR-1:0] d,
  output logic [ADDR-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!hold) begin
      if (load) q <= d;
      else      q <= q + ADDR'(1);
    end
  end

endmodule

// File: rtl/my_cpu.sv
// Hack CPU execute stage: decodes A/C instructions, holds A, D and PC,
// drives the ALU and produces RAM writes and conditional jumps.
module my_cpu
  import my_cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic [WORD-1:0] inst,
  input  logic [WORD-1:0] in_m,
  output logic [WORD-1:0] out_m,
  output logic            write_m,
  output logic [ADDR-1:0] address_m,
  output logic [ADDR-1:0] pc
);

  ctrl_t                  ctrl;
  logic [WORD-1:0]        a_q, d_q, y_op, a_next, alu_res;
  logic signed [WORD-1:0] alu_out;
  logic                   zr, ng, jmp, a_load, d_load;
  logic                   alu_zr_unused, alu_ng_unused;

  assign ctrl = decode(inst);
  assign y_op = ctrl.a ? in_m : a_q;

  hack_alu u_alu (
    .x    (d_q),
    .y    (y_op),
    .ctrl (ctrl.comp),
    .out  (alu_res),
    .zr   (alu_zr_unused),
    .ng   (alu_ng_unused)
  );

  // Flags are derived here so the jump logic does not depend on the ALU's own flag outputs.
  assign alu_out = alu_res;
  assign zr      = (alu_out == '0);
  assign ng      = (alu_out < 0);
  assign jmp     = ctrl.cinst & ((ctrl.j_lt & ng) | (ctrl.j_eq & zr) | (ctrl.j_gt & ~zr & ~ng));

  assign a_load  = ~ctrl.cinst | ctrl.dst_a;
  assign a_next  = ctrl.cinst ? alu_res : {1'b0, inst[ADDR-1:0]};
  assign d_load  = ctrl.cinst & ctrl.dst_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      d_q <= '0;
    end else if (!stall) begin
      if (a_load) a_q <= a_next;
      if (d_load) d_q <= alu_res;
    end
  end

  // Jump target is the A value from before this edge, even when dest A also loads.
  my_pc u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (stall),
    .load  (jmp),
    .d     (a_q[ADDR-1:0]),
    .q     (pc)
  );

  assign out_m     = alu_res;
  assign address_m = a_q[ADDR-1:0];
  assign write_m   = ctrl.cinst & ctrl.dst_m & ~stall & rst_n;

endmodule
